// File: rtl/poly_reduction_ctrl.sv
// Sequencer that folds a 2N-1 coefficient product modulo X^N - 1: it streams coefficient
// pairs (i, i+N) to the poly_reduction stage and writes the N reduced results back out.
module poly_reduction_ctrl #(
  parameter int unsigned N  = 509,
  parameter int unsigned AW = 10,
  parameter int unsigned OW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    poly_q_in,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr_a,
  output logic [AW-1:0] rd_addr_b,
  input  logic [23:0]   rd_data_a,
  input  logic [23:0]   rd_data_b,
  output logic [23:0]   red_in_1,
  output logic [23:0]   red_in_2,
  output logic [1:0]    red_poly_q,
  input  logic [12:0]   red_out,
  output logic          wr_en,
  output logic [OW-1:0] wr_addr,
  output logic [12:0]   wr_data,
  output logic          busy,
  output logic          done
);

  localparam int unsigned DW = 24;
  localparam int unsigned RW = 13;
  localparam int unsigned QW = 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [OW-1:0] FIRST_IDX = '0;
  localparam logic [OW-1:0] LAST_IDX  = OW'(N - 1);
  localparam logic [AW-1:0] N_ADDR    = AW'(N);

  // Upper-half address for index i; coefficient 2N-1 does not exist, so the last slot reads 0.
  function automatic logic [AW-1:0] hi_addr(input logic [OW-1:0] i);
    hi_addr = (i == LAST_IDX) ? '0 : (AW'(i) + N_ADDR);
  endfunction

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [OW-1:0] idx;
  logic [OW-1:0] idx_nxt;
  logic          rd_en_nxt;
  logic [AW-1:0] addr_a_nxt;
  logic [AW-1:0] addr_b_nxt;
  logic [QW-1:0] poly_q_nxt;
  logic          busy_nxt;
  logic          done_nxt;

  // Index tracking pipeline: stage1 = RAM data cycle, stage2 = red_out valid cycle.
  logic          s1_vld;
  logic [OW-1:0] s1_idx;
  logic          s2_vld;
  logic [OW-1:0] s2_idx;

  // Next-state and next-output decode.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    rd_en_nxt  = 1'b0;
    addr_a_nxt = '0;
    addr_b_nxt = '0;
    poly_q_nxt = red_poly_q;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt  = S_READ;
          idx_nxt    = FIRST_IDX;
          rd_en_nxt  = 1'b1;
          addr_a_nxt = AW'(FIRST_IDX);
          addr_b_nxt = hi_addr(FIRST_IDX);
          poly_q_nxt = poly_q_in;
          busy_nxt   = 1'b1;
        end
      end
      S_READ: begin
        if (idx == LAST_IDX) begin
          state_nxt = S_DRAIN;
        end else begin
          idx_nxt    = idx + OW'(1);
          rd_en_nxt  = 1'b1;
          addr_a_nxt = AW'(idx_nxt);
          addr_b_nxt = hi_addr(idx_nxt);
        end
      end
      S_DRAIN: begin
        // The write for the last index is on the port this cycle.
        if (wr_en && (wr_addr == LAST_IDX)) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and registered control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      rd_en      <= 1'b0;
      rd_addr_a  <= '0;
      rd_addr_b  <= '0;
      red_poly_q <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      rd_en      <= rd_en_nxt;
      rd_addr_a  <= addr_a_nxt;
      rd_addr_b  <= addr_b_nxt;
      red_poly_q <= poly_q_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

  // Valid/index shift pipeline and the registered output-RAM write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_idx  <= '0;
      s2_vld  <= 1'b0;
      s2_idx  <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      s1_vld <= rd_en;
      s1_idx <= idx;
      s2_vld <= s1_vld;
      s2_idx <= s1_idx;
      wr_en  <= s2_vld;
      if (s2_vld) begin
        wr_addr <= s2_idx;
        wr_data <= RW'(red_out);
      end
    end
  end

  // Operands follow the RAM data only in its valid cycle; otherwise held at zero.
  always_comb begin
    red_in_1 = '0;
    red_in_2 = '0;
    if (s1_vld) begin
      red_in_1 = DW'(rd_data_a);
      if (s1_idx != LAST_IDX) begin
        red_in_2 = DW'(rd_data_b);
      end
    end
  end

endmodule

// File: tb/tb_poly_reduction_ctrl.sv
// Bench for poly_reduction_ctrl: an N=7 instance for directed vectors and a default N=509 instance.
module tb_poly_reduction_ctrl;

  localparam int unsigned N7   = 7;
  localparam int unsigned NB   = 509;
  localparam int unsigned MODQ = 12587009;
  localparam int unsigned PMAX = 2 * NB - 1;
  localparam logic [23:0] GARB = 24'hABCDEF;

  typedef struct {
    logic        rd_en;
    logic [9:0]  ra;
    logic [9:0]  rb;
    logic [23:0] r1;
    logic [23:0] r2;
    logic [1:0]  rpq;
    logic        we;
    logic [8:0]  wa;
    logic [12:0] wd;
    logic        busy;
    logic        done;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start7, startB;
  logic [1:0]  pq7, pqB;
  logic        rd_en7, rd_enB;
  logic [3:0]  ra7, rb7;
  logic [9:0]  raB, rbB;
  logic [23:0] da7, db7, daB, dbB;
  logic [23:0] r1_7, r2_7, r1_B, r2_B;
  logic [1:0]  rpq7, rpqB;
  logic [12:0] rout7, routB;
  logic        we7, weB;
  logic [2:0]  wa7;
  logic [8:0]  waB;
  logic [12:0] wd7, wdB;
  logic        busy7, busyB, done7, doneB;

  poly_reduction_ctrl #(.N(7), .AW(4), .OW(3)) dut7 (
    .clk(clk), .rst_n(rst_n), .start(start7), .poly_q_in(pq7),
    .rd_en(rd_en7), .rd_addr_a(ra7), .rd_addr_b(rb7), .rd_data_a(da7), .rd_data_b(db7),
    .red_in_1(r1_7), .red_in_2(r2_7), .red_poly_q(rpq7), .red_out(rout7),
    .wr_en(we7), .wr_addr(wa7), .wr_data(wd7), .busy(busy7), .done(done7));

  poly_reduction_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(startB), .poly_q_in(pqB),
    .rd_en(rd_enB), .rd_addr_a(raB), .rd_addr_b(rbB), .rd_data_a(daB), .rd_data_b(dbB),
    .red_in_1(r1_B), .red_in_2(r2_B), .red_poly_q(rpqB), .red_out(routB),
    .wr_en(weB), .wr_addr(waB), .wr_data(wdB), .busy(busyB), .done(doneB));

  logic [23:0] prod [2][PMAX];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          c0 [2];
  bit          run [2];
  logic [1:0]  mq [2];
  logic [12:0] wlog [2][NB];
  int          wcnt [2];
  int          dcnt [2];
  int          done_k [2];
  logic [23:0] r2_last;

  function automatic int nof(input int g);
    return (g == 0) ? int'(N7) : int'(NB);
  endfunction

  function automatic logic [23:0] mem(input int g, input int a);
    if (a < 2 * nof(g) - 1) return prod[g][a];
    return GARB;
  endfunction

  // Behavioural stand-in for poly_reduction: sum mod q, then truncate to the selected width.
  function automatic logic [12:0] red_f(input logic [23:0] a, input logic [23:0] b, input logic [1:0] q);
    logic [31:0] s;
    s = (32'(a) + 32'(b)) % 32'(MODQ);
    case (q)
      2'b00:   s = s % 32'd2048;
      2'b01:   s = s % 32'd4096;
      default: s = s % 32'd8192;
    endcase
    return 13'(s);
  endfunction

  function automatic obs_t sample(input int g);
    obs_t o;
    if (g == 0) begin
      o.rd_en = rd_en7; o.ra = 10'(ra7); o.rb = 10'(rb7); o.r1 = r1_7; o.r2 = r2_7;
      o.rpq = rpq7; o.we = we7; o.wa = 9'(wa7); o.wd = wd7; o.busy = busy7; o.done = done7;
    end else begin
      o.rd_en = rd_enB; o.ra = raB; o.rb = rbB; o.r1 = r1_B; o.r2 = r2_B;
      o.rpq = rpqB; o.we = weB; o.wa = waB; o.wd = wdB; o.busy = busyB; o.done = doneB;
    end
    return o;
  endfunction

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t: got %0d expected %0d", nm, g, $time, act, exp);
    end
  endtask

  // Product RAM and reduction-stage stand-ins (one-cycle latency each).
  always @(posedge clk) begin
    da7   <= rd_en7 ? mem(0, int'(ra7)) : GARB;
    db7   <= rd_en7 ? mem(0, int'(rb7)) : GARB;
    daB   <= rd_enB ? mem(1, int'(raB)) : GARB;
    dbB   <= rd_enB ? mem(1, int'(rbB)) : GARB;
    rout7 <= red_f(r1_7, r2_7, rpq7);
    routB <= red_f(r1_B, r2_B, rpqB);
  end

  // Model: a run is accepted when start is seen and no earlier run is within cycles 1..N+4.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < 2; g++) begin
        run[g] = 1'b0;
        mq[g]  = 2'b00;
      end
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (((g == 0) ? start7 : startB) === 1'b1 && !(run[g] && (cyc - c0[g]) <= nof(g) + 4)) begin
          run[g] = 1'b1;
          c0[g]  = cyc;
          mq[g]  = (g == 0) ? pq7 : pqB;
        end
      end
      cyc++;
    end
  end

  task automatic check_dut(input int g);
    obs_t o;
    int n, k, i, j, w;
    bit e_rd, e_s1, e_we;
    logic [23:0] e_r2;
    o = sample(g);
    n = nof(g);
    if (!rst_n) begin
      chk("rst_rd_en", g, 32'(o.rd_en), 0);
      chk("rst_rd_addr_a", g, 32'(o.ra), 0);
      chk("rst_rd_addr_b", g, 32'(o.rb), 0);
      chk("rst_red_in_1", g, 32'(o.r1), 0);
      chk("rst_red_in_2", g, 32'(o.r2), 0);
      chk("rst_red_poly_q", g, 32'(o.rpq), 0);
      chk("rst_wr_en", g, 32'(o.we), 0);
      chk("rst_wr_addr", g, 32'(o.wa), 0);
      chk("rst_wr_data", g, 32'(o.wd), 0);
      chk("rst_busy", g, 32'(o.busy), 0);
      chk("rst_done", g, 32'(o.done), 0);
      return;
    end
    k = run[g] ? (cyc - c0[g]) : -1;
    e_rd = (k >= 1 && k <= n);
    i = k - 1;
    e_s1 = (k >= 2 && k <= n + 1);
    j = k - 2;
    e_we = (k >= 4 && k <= n + 3);
    w = k - 4;
    chk("rd_en", g, 32'(o.rd_en), 32'(e_rd));
    chk("rd_addr_a", g, 32'(o.ra), e_rd ? 32'(i) : 0);
    chk("rd_addr_b", g, 32'(o.rb), e_rd ? ((i == n - 1) ? 0 : 32'(i + n)) : 0);
    chk("red_in_1", g, 32'(o.r1), e_s1 ? 32'(prod[g][j]) : 0);
    e_r2 = (e_s1 && j < n - 1) ? prod[g][j + n] : 24'd0;
    chk("red_in_2", g, 32'(o.r2), 32'(e_r2));
    chk("red_poly_q", g, 32'(o.rpq), 32'(mq[g]));
    chk("wr_en", g, 32'(o.we), 32'(e_we));
    if (e_we) begin
      chk("wr_addr", g, 32'(o.wa), 32'(w));
      chk("wr_data", g, 32'(o.wd),
          32'(red_f(prod[g][w], (w < n - 1) ? prod[g][w + n] : 24'd0, mq[g])));
    end
    chk("busy", g, 32'(o.busy), 32'(k >= 1 && k <= n + 3));
    chk("done", g, 32'(o.done), 32'(k == n + 4));
    if (o.we === 1'b1) begin
      wcnt[g]++;
      if (int'(o.wa) < n) wlog[g][o.wa] = o.wd;
    end
    if (o.done === 1'b1) begin
      dcnt[g]++;
      done_k[g] = k;
    end
    if (g == 0 && k == n + 1) r2_last = o.r2;
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) check_dut(g);
  end

  task automatic wait_done(input int g, input int budget);
    bit   seen;
    obs_t o;
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      o = sample(g);
      if (o.done === 1'b1) seen = 1'b1;
    end
    chk("done_timeout", g, 32'(seen), 1);
  endtask

  task automatic clear_logs(input int g);
    wcnt[g] = 0;
    dcnt[g] = 0;
    done_k[g] = -1;
  endtask

  task automatic go7(input logic [1:0] q);
    clear_logs(0);
    pq7 = q;
    start7 = 1'b1;
    @(negedge clk);
    start7 = 1'b0;
  endtask

  int exp1 [7] = '{9, 11, 13, 15, 17, 19, 7};

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    start7 = 1'b0; startB = 1'b0; pq7 = 2'b00; pqB = 2'b00;
    for (int g = 0; g < 2; g++) begin
      for (int a = 0; a < int'(PMAX); a++) prod[g][a] = 24'd0;
      clear_logs(g);
    end
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 0, 32'(busy7), 0);
    chk("reset_wr_en", 1, 32'(weB), 0);

    // Sum of coefficient pairs, start in the first clock after reset release.
    for (int a = 0; a < 13; a++) prod[0][a] = 24'(a + 1);
    rst_n = 1'b1;
    go7(2'b11);
    wait_done(0, 40);
    repeat (2) @(negedge clk);
    for (int a = 0; a < 7; a++) chk("sum_vec", 0, 32'(wlog[0][a]), 32'(exp1[a]));
    chk("sum_done_cycle", 0, 32'(done_k[0]), 11);
    chk("sum_wcnt", 0, 32'(wcnt[0]), 7);

    // Lifted -1 plus 1 wraps to 0; last index has no upper coefficient.
    for (int a = 0; a < 13; a++) prod[0][a] = 24'(100 * a + 3);
    prod[0][0] = 24'd12587008;
    prod[0][7] = 24'd1;
    prod[0][6] = 24'd6293505;
    go7(2'b11);
    wait_done(0, 40);
    repeat (2) @(negedge clk);
    chk("wrap_addr0", 0, 32'(wlog[0][0]), 0);
    chk("pair_addr1", 0, 32'(wlog[0][1]), 906);
    chk("last_addr6", 0, 32'(wlog[0][6]), 2049);
    chk("last_red_in_2", 0, 32'(r2_last), 0);

    // Extra starts at cycle 3 and in the done cycle are ignored.
    clear_logs(0);
    pq7 = 2'b10;
    start7 = 1'b1;
    @(negedge clk); start7 = 1'b0;
    @(negedge clk);
    @(negedge clk); start7 = 1'b1;
    @(negedge clk); start7 = 1'b0;
    wait_done(0, 40);
    start7 = 1'b1;
    @(negedge clk); start7 = 1'b0;
    repeat (14) @(negedge clk);
    chk("busy_start_wcnt", 0, 32'(wcnt[0]), 7);
    chk("busy_start_dcnt", 0, 32'(dcnt[0]), 1);

    // poly_q is captured at start; a mid-run change has no effect.
    for (int a = 0; a < 13; a++) prod[0][a] = 24'd8191;
    go7(2'b00);
    repeat (3) @(negedge clk);
    pq7 = 2'b11;
    repeat (2) @(negedge clk);
    chk("polyq_held", 0, 32'(rpq7), 0);
    wait_done(0, 40);
    repeat (2) @(negedge clk);
    chk("polyq_addr0", 0, 32'(wlog[0][0]), 2046);
    chk("polyq_addr6", 0, 32'(wlog[0][6]), 2047);
    for (int a = 0; a < 7; a++) chk("polyq_top_bits", 0, 32'(wlog[0][a][12:11]), 0);

    // Asynchronous reset mid-run aborts; a fresh run then completes.
    for (int a = 0; a < 13; a++) prod[0][a] = 24'(a + 1);
    go7(2'b10);
    repeat (4) @(negedge clk);
    chk("pre_rst_wr_en", 0, 32'(we7), 1);
    chk("pre_rst_busy", 0, 32'(busy7), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_wr_en", 0, 32'(we7), 0);
    chk("async_busy", 0, 32'(busy7), 0);
    chk("async_rd_en", 0, 32'(rd_en7), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs(0);
    repeat (15) @(negedge clk);
    chk("post_rst_no_wr", 0, 32'(wcnt[0]), 0);
    go7(2'b01);
    wait_done(0, 40);
    repeat (2) @(negedge clk);
    chk("rerun_wcnt", 0, 32'(wcnt[0]), 7);
    chk("rerun_dcnt", 0, 32'(dcnt[0]), 1);

    // Full-size run with random products.
    for (int a = 0; a < int'(PMAX); a++) prod[1][a] = 24'($urandom_range(0, MODQ - 1));
    clear_logs(1);
    pqB = 2'b01;
    startB = 1'b1;
    @(negedge clk); startB = 1'b0;
    wait_done(1, 600);
    repeat (2) @(negedge clk);
    chk("big_done_cycle", 1, 32'(done_k[1]), 513);
    chk("big_wcnt", 1, 32'(wcnt[1]), 509);
    chk("big_dcnt", 1, 32'(dcnt[1]), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/poly_reduction_ctrl.md
POLY_REDUCTION_CTRL -- requirements
Module: poly_reduction_ctrl

Interface
REQ-001 Parameter N, default 509; NTRU ring degree, reduction modulo X^N - 1.
REQ-002 Parameter AW, default 10; product-RAM address width, SHALL satisfy 2^AW >= 2N-1.
REQ-003 Parameter OW, default 9; output-RAM address width, SHALL satisfy 2^OW >= N.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  one-cycle request to reduce a 2N-1 coefficient product.
REQ-007 poly_q_in  in  2  output-width select, forwarded to reduction stage.
REQ-008 rd_en  out  1  product-RAM read strobe, both ports.
REQ-009 rd_addr_a / rd_addr_b  out  AW each  product-RAM addresses, low and high half.
REQ-010 rd_data_a / rd_data_b  in  24 each  product-RAM data, valid exactly 1 cycle after rd_en.
REQ-011 red_in_1 / red_in_2  out  24 each  operands to poly_reduction (which registers them, result valid 1 cycle later).
REQ-012 red_poly_q  out  2  poly_q to poly_reduction.
REQ-013 red_out  in  13  reduced coefficient from poly_reduction.
REQ-014 wr_en / wr_addr / wr_data  out  1 / OW / 13  output-RAM write port.
REQ-015 busy  out  1  high from accepted start until done.
REQ-016 done  out  1  one-cycle completion pulse.

Function
REQ-017 FSM states IDLE, READ, DRAIN, DONE; IDLE on reset.
REQ-018 IDLE: start=1 -> latch poly_q_in into red_poly_q, clear index i to 0, go READ; start=0 -> stay.
REQ-019 start while busy SHALL be ignored with no effect on the run in progress.
REQ-020 READ: each cycle rd_en=1, rd_addr_a=i, rd_addr_b=i+N, i increments; after i=N-1 issued go DRAIN.
REQ-021 For i=N-1, rd_addr_b SHALL be 0 and the block SHALL force red_in_2 to 24'd0 (coefficient 2N-1 does not exist).
REQ-022 red_in_1=rd_data_a, red_in_2=rd_data_b (or 0 per REQ-021), combinational, valid in the cycle after the matching rd_en.
REQ-023 A 3-stage valid/index shift pipeline SHALL track each issued i: stage1 = RAM data cycle, stage2 = red_out valid cycle, stage3 = registered write.
REQ-024 Write for index i SHALL appear exactly 3 cycles after its rd_en: wr_en=1, wr_addr=i, wr_data=red_out captured in stage2.
REQ-025 Writes SHALL occur on N consecutive cycles, addresses 0..N-1 in increasing order, no gaps, no duplicates.
REQ-026 DRAIN: rd_en=0; remain until final write (i=N-1) has been issued, then go DONE.
REQ-027 DONE: done=1 for exactly one cycle, busy=0 in that same cycle, return to IDLE; start in the DONE cycle is ignored.
REQ-028 Total run: start accepted at cycle 0 -> first rd_en cycle 1 -> last write cycle N+3 -> done cycle N+4.
REQ-029 red_poly_q SHALL remain constant from start acceptance to done; poly_q_in changes mid-run have no effect.
REQ-030 rd_addr_a/b, red_in_1/2 SHALL be 0 whenever not driven by an active read; no X propagation to outputs.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, rd_en=0, wr_en=0, busy=0, done=0, wr_addr=0, wr_data=0, rd_addr_a/b=0, red_poly_q=0, pipeline valids cleared.
REQ-032 Reset mid-run SHALL abort with no further writes after release; partial output RAM contents are undefined to the consumer.
REQ-033 First start after reset release SHALL be accepted in the first clock with rst_n=1.

Verification
REQ-034 N=7, product p_k=k+1 for k=0..12, poly_q_in=2'b11, start -> writes addr 0..6 = p_i+p_{i+7}: 9,11,13,15,17,19,7 (after lift, in range), done at cycle 11.
REQ-035 N=7, p_0=12587008 (=-1 lifted), p_7=1 -> wr_data at addr 0 = 0; p_6=6293505, p_13 absent -> red_in_2=0 at i=6 checked.
REQ-036 start pulsed again at cycles 3 and 11 (DONE) of a run -> single run, exactly N writes, one done pulse.
REQ-037 poly_q_in=2'b00 at start, switched to 2'b11 at cycle 4 -> red_poly_q stays 2'b00 throughout, wr_data bits[12:11]=0.
REQ-038 rst_n low at cycle 5 of a run -> wr_en/busy drop asynchronously same cycle, no writes after release, new start completes normally with N writes.
REQ-039 Default N=509, random 24-bit products < 12587009, poly_q 2'b01 -> all 509 writes match reference model, done at cycle 513.
